// File: rtl/scr1_mem_arb_pkg.sv
// Shared memory-interface types for the IMEM/DMEM arbiter: command, width,
// response and requester-id encodings plus arbiter FSM states.
package scr1_mem_arb_pkg;

    localparam int SCR1_MEM_DATA_WIDTH = 64;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10,
        SCR1_MEM_WIDTH_DWORD = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

    typedef enum logic {
        SCR1_ARB_IMEM = 1'b0,
        SCR1_ARB_DMEM = 1'b1
    } type_scr1_arb_port_e;

    typedef enum logic {
        ARB_FREE = 1'b0,
        ARB_HOLD = 1'b1
    } type_scr1_arb_fsm_e;

    // Error responses complete a transaction just like OK ones.
    function automatic logic scr1_resp_valid(input type_scr1_mem_resp_e resp);
        return resp != SCR1_MEM_RESP_NOTRDY;
    endfunction

endpackage

// File: rtl/scr1_mem_arb_ord_fifo.sv
// Order FIFO for the memory arbiter: remembers which requester owns each
// outstanding bridge transaction so responses can be routed back in order.
module scr1_arb_ord_fifo
    import scr1_mem_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_push,
    input  type_scr1_arb_port_e i_push_id,
    input  logic                i_pop,
    output type_scr1_arb_port_e o_head_id,
    output logic                o_empty,
    output logic                o_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]    r_wptr;
    logic [PTR_W-1:0]    r_rptr;
    logic [CNT_W-1:0]    r_count;
    type_scr1_arb_port_e r_ids [DEPTH];

    logic w_push;
    logic w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == FULL_CNT);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ids[r_wptr] <= i_push_id;
        end
    end

    assign o_head_id = r_ids[r_rptr];

endmodule

// File: rtl/scr1_mem_arb.sv
// IMEM/DMEM arbiter in front of the AXI bridge. Tie-break is round-robin by
// default; defining SCR1_MEM_ARB_DMEM_PRIO_EN gives DMEM fixed priority.
module scr1_mem_arb
    import scr1_mem_arb_pkg::*;
#(
    parameter int ARB_ORD_DEPTH  = 4,
    parameter int ARB_ADDR_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      i_imem_req,
    output logic                      o_imem_req_ack,
    input  type_scr1_mem_cmd_e        i_imem_cmd,
    input  type_scr1_mem_width_e      i_imem_width,
    input  logic [ARB_ADDR_WIDTH-1:0] i_imem_addr,
    input  logic [63:0]               i_imem_wdata,
    output logic [63:0]               o_imem_rdata,
    output type_scr1_mem_resp_e       o_imem_resp,

    input  logic                      i_dmem_req,
    output logic                      o_dmem_req_ack,
    input  type_scr1_mem_cmd_e        i_dmem_cmd,
    input  type_scr1_mem_width_e      i_dmem_width,
    input  logic [ARB_ADDR_WIDTH-1:0] i_dmem_addr,
    input  logic [63:0]               i_dmem_wdata,
    output logic [63:0]               o_dmem_rdata,
    output type_scr1_mem_resp_e       o_dmem_resp,

    output logic                      o_mem_req,
    input  logic                      i_mem_req_ack,
    output type_scr1_mem_cmd_e        o_mem_cmd,
    output type_scr1_mem_width_e      o_mem_width,
    output logic [ARB_ADDR_WIDTH-1:0] o_mem_addr,
    output logic [63:0]               o_mem_wdata,
    input  logic [63:0]               i_mem_rdata,
    input  type_scr1_mem_resp_e       i_mem_resp,
    input  logic                      i_mem_idle,

    output logic                      o_arb_idle,
    output logic                      o_arb_err
);

    type_scr1_arb_fsm_e  r_state;
    type_scr1_arb_fsm_e  w_state_next;
    type_scr1_arb_port_e r_owner;
    type_scr1_arb_port_e w_gnt;
    type_scr1_arb_port_e w_head_id;
    logic                w_gnt_req;
    logic                w_accept;
    logic                w_resp_vld;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic                r_arb_err;

`ifndef SCR1_MEM_ARB_DMEM_PRIO_EN
    type_scr1_arb_port_e r_last_gnt;
`endif

    // HOLD keeps the owner stable until the bridge takes its request.
    always_comb begin
        w_gnt = SCR1_ARB_IMEM;
        if (r_state == ARB_HOLD) begin
            w_gnt = r_owner;
        end else if (i_imem_req && i_dmem_req) begin
`ifdef SCR1_MEM_ARB_DMEM_PRIO_EN
            w_gnt = SCR1_ARB_DMEM;
`else
            w_gnt = (r_last_gnt == SCR1_ARB_DMEM) ? SCR1_ARB_IMEM : SCR1_ARB_DMEM;
`endif
        end else if (i_dmem_req) begin
            w_gnt = SCR1_ARB_DMEM;
        end
    end

    assign w_gnt_req      = (w_gnt == SCR1_ARB_DMEM) ? i_dmem_req : i_imem_req;
    assign o_mem_req      = rst_n & w_gnt_req & ~w_full;
    assign w_accept       = o_mem_req & i_mem_req_ack;
    assign o_imem_req_ack = w_accept & (w_gnt == SCR1_ARB_IMEM);
    assign o_dmem_req_ack = w_accept & (w_gnt == SCR1_ARB_DMEM);

    always_comb begin
        o_mem_cmd   = i_imem_cmd;
        o_mem_width = i_imem_width;
        o_mem_addr  = i_imem_addr;
        o_mem_wdata = i_imem_wdata;
        if (w_gnt == SCR1_ARB_DMEM) begin
            o_mem_cmd   = i_dmem_cmd;
            o_mem_width = i_dmem_width;
            o_mem_addr  = i_dmem_addr;
            o_mem_wdata = i_dmem_wdata;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ARB_FREE: begin
                if (o_mem_req && !i_mem_req_ack) begin
                    w_state_next = ARB_HOLD;
                end
            end
            ARB_HOLD: begin
                if (w_accept || !w_gnt_req) begin
                    w_state_next = ARB_FREE;
                end
            end
            default: w_state_next = ARB_FREE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB_FREE;
            r_owner <= SCR1_ARB_IMEM;
        end else begin
            r_state <= w_state_next;
            if (r_state == ARB_FREE && w_state_next == ARB_HOLD) begin
                r_owner <= w_gnt;
            end
        end
    end

`ifndef SCR1_MEM_ARB_DMEM_PRIO_EN
    // Resetting to DMEM makes IMEM the winner of the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_gnt <= SCR1_ARB_DMEM;
        end else if (w_accept) begin
            r_last_gnt <= w_gnt;
        end
    end
`endif

    assign w_resp_vld = scr1_resp_valid(i_mem_resp);
    assign w_pop      = w_resp_vld & ~w_empty;

    scr1_arb_ord_fifo #(
        .DEPTH (ARB_ORD_DEPTH)
    ) u_ord_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_accept),
        .i_push_id (w_gnt),
        .i_pop     (w_pop),
        .o_head_id (w_head_id),
        .o_empty   (w_empty),
        .o_full    (w_full)
    );

    // A response with nothing outstanding is dropped for both ports.
    always_comb begin
        o_imem_resp  = SCR1_MEM_RESP_NOTRDY;
        o_imem_rdata = '0;
        o_dmem_resp  = SCR1_MEM_RESP_NOTRDY;
        o_dmem_rdata = '0;
        if (!w_empty) begin
            if (w_head_id == SCR1_ARB_IMEM) begin
                o_imem_resp  = i_mem_resp;
                o_imem_rdata = i_mem_rdata;
            end else begin
                o_dmem_resp  = i_mem_resp;
                o_dmem_rdata = i_mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_arb_err <= 1'b0;
        end else if (w_resp_vld && w_empty) begin
            r_arb_err <= 1'b1;
        end
    end

    assign o_arb_err  = r_arb_err;
    assign o_arb_idle = i_mem_idle & w_empty;

endmodule

// File: tb/tb_scr1_mem_arb.sv
// Self-checking bench for scr1_mem_arb: directed scenarios with a scoreboard
// queue of expected response owners, one per accepted request.
module tb_scr1_mem_arb;
    import scr1_mem_arb_pkg::*;

    localparam int AW = 32;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;

    logic                 imemReq, dmemReq;
    logic                 imemReqAck, dmemReqAck;
    type_scr1_mem_cmd_e   imemCmd, dmemCmd, memCmd;
    type_scr1_mem_width_e imemWidth, dmemWidth, memWidth;
    logic [AW-1:0]        imemAddr, dmemAddr, memAddr;
    logic [63:0]          imemWdata, dmemWdata, memWdata;
    logic [63:0]          imemRdata, dmemRdata, memRdata;
    type_scr1_mem_resp_e  imemResp, dmemResp, memResp;
    logic                 memReq, memReqAck, memIdle;
    logic                 arbIdle, arbErr;

    int nChecks = 0;
    int nPass   = 0;
    type_scr1_arb_port_e ordQ[$];

    always #5 clk = ~clk;

    scr1_mem_arb #(
        .ARB_ORD_DEPTH  (4),
        .ARB_ADDR_WIDTH (AW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_imem_req     (imemReq),
        .o_imem_req_ack (imemReqAck),
        .i_imem_cmd     (imemCmd),
        .i_imem_width   (imemWidth),
        .i_imem_addr    (imemAddr),
        .i_imem_wdata   (imemWdata),
        .o_imem_rdata   (imemRdata),
        .o_imem_resp    (imemResp),
        .i_dmem_req     (dmemReq),
        .o_dmem_req_ack (dmemReqAck),
        .i_dmem_cmd     (dmemCmd),
        .i_dmem_width   (dmemWidth),
        .i_dmem_addr    (dmemAddr),
        .i_dmem_wdata   (dmemWdata),
        .o_dmem_rdata   (dmemRdata),
        .o_dmem_resp    (dmemResp),
        .o_mem_req      (memReq),
        .i_mem_req_ack  (memReqAck),
        .o_mem_cmd      (memCmd),
        .o_mem_width    (memWidth),
        .o_mem_addr     (memAddr),
        .o_mem_wdata    (memWdata),
        .i_mem_rdata    (memRdata),
        .i_mem_resp     (memResp),
        .i_mem_idle     (memIdle),
        .o_arb_idle     (arbIdle),
        .o_arb_err      (arbErr)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        if (obs === exp) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: observed %0h, required %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive just after the rising edge, return at the falling edge.
    task automatic applyStimulus(input logic iReq, input logic dReq, input logic ack,
                                 input type_scr1_mem_resp_e resp, input logic [63:0] rdata);
        @(posedge clk);
        #1;
        imemReq   = iReq;
        dmemReq   = dReq;
        memReqAck = ack;
        memResp   = resp;
        memRdata  = rdata;
        @(negedge clk);
    endtask

    task automatic issueOne(input string tag, input type_scr1_arb_port_e port);
        logic [AW-1:0] expAddr;
        logic [63:0]   expWdata;
        expAddr  = (port == SCR1_ARB_IMEM) ? imemAddr : dmemAddr;
        expWdata = (port == SCR1_ARB_IMEM) ? imemWdata : dmemWdata;
        ordQ.push_back(port);
        applyStimulus(port == SCR1_ARB_IMEM, port == SCR1_ARB_DMEM, 1'b1, SCR1_MEM_RESP_NOTRDY, 64'h0);
        checkOutput({tag, "_imem_ack"}, 64'(imemReqAck), 64'(port == SCR1_ARB_IMEM));
        checkOutput({tag, "_dmem_ack"}, 64'(dmemReqAck), 64'(port == SCR1_ARB_DMEM));
        checkOutput({tag, "_addr"}, 64'(memAddr), 64'(expAddr));
        checkOutput({tag, "_wdata"}, memWdata, expWdata);
    endtask

    task automatic checkRouting(input string tag, input type_scr1_mem_resp_e resp, input logic [63:0] rdata);
        type_scr1_arb_port_e owner;
        owner = (ordQ.size() > 0) ? ordQ.pop_front() : SCR1_ARB_IMEM;
        checkOutput({tag, "_imem_resp"}, 64'(imemResp),
                    64'((owner == SCR1_ARB_IMEM) ? resp : SCR1_MEM_RESP_NOTRDY));
        checkOutput({tag, "_imem_rdata"}, imemRdata, (owner == SCR1_ARB_IMEM) ? rdata : 64'h0);
        checkOutput({tag, "_dmem_resp"}, 64'(dmemResp),
                    64'((owner == SCR1_ARB_DMEM) ? resp : SCR1_MEM_RESP_NOTRDY));
        checkOutput({tag, "_dmem_rdata"}, dmemRdata, (owner == SCR1_ARB_DMEM) ? rdata : 64'h0);
    endtask

    task automatic respond(input string tag, input type_scr1_mem_resp_e resp, input logic [63:0] rdata);
        applyStimulus(1'b0, 1'b0, 1'b0, resp, rdata);
        checkRouting(tag, resp, rdata);
    endtask

    initial begin
        imemReq   = 1'b1;
        dmemReq   = 1'b1;
        imemCmd   = SCR1_MEM_CMD_RD;
        dmemCmd   = SCR1_MEM_CMD_RD;
        imemWidth = SCR1_MEM_WIDTH_WORD;
        dmemWidth = SCR1_MEM_WIDTH_WORD;
        imemAddr  = 32'h0000_0100;
        dmemAddr  = 32'h0000_0200;
        imemWdata = 64'h1111_2222_3333_4444;
        dmemWdata = 64'h5555_6666_7777_8888;
        memReqAck = 1'b1;
        memResp   = SCR1_MEM_RESP_RDY_OK;
        memRdata  = 64'hA5;
        memIdle   = 1'b1;

        // Reset state with live requests and a live response on the inputs
        #2;
        checkOutput("rst_mem_req", 64'(memReq), 64'h0);
        checkOutput("rst_imem_ack", 64'(imemReqAck), 64'h0);
        checkOutput("rst_dmem_ack", 64'(dmemReqAck), 64'h0);
        checkOutput("rst_imem_resp", 64'(imemResp), 64'(SCR1_MEM_RESP_NOTRDY));
        checkOutput("rst_dmem_rdata", dmemRdata, 64'h0);
        checkOutput("rst_arb_err", 64'(arbErr), 64'h0);
        checkOutput("rst_idle_hi", 64'(arbIdle), 64'h1);
        memIdle = 1'b0;
        #1;
        checkOutput("rst_idle_lo", 64'(arbIdle), 64'h0);
        memIdle   = 1'b1;
        imemReq   = 1'b0;
        dmemReq   = 1'b0;
        memReqAck = 1'b0;
        memResp   = SCR1_MEM_RESP_NOTRDY;
        memRdata  = 64'h0;
        @(negedge clk);
        rst_n = 1'b1;

`ifndef SCR1_MEM_ARB_DMEM_PRIO_EN
        // Round-robin tie: a small model of last grant predicts the winner
        begin
            type_scr1_arb_port_e lastGnt;
            type_scr1_arb_port_e expWin;
            lastGnt = SCR1_ARB_DMEM;
            for (int i = 0; i < 4; i++) begin
                expWin = (lastGnt == SCR1_ARB_DMEM) ? SCR1_ARB_IMEM : SCR1_ARB_DMEM;
                ordQ.push_back(expWin);
                applyStimulus(1'b1, 1'b1, 1'b1, SCR1_MEM_RESP_NOTRDY, 64'h0);
                checkOutput($sformatf("tie%0d_imem_ack", i), 64'(imemReqAck), 64'(expWin == SCR1_ARB_IMEM));
                checkOutput($sformatf("tie%0d_dmem_ack", i), 64'(dmemReqAck), 64'(expWin == SCR1_ARB_DMEM));
                checkOutput($sformatf("tie%0d_addr", i), 64'(memAddr),
                            64'((expWin == SCR1_ARB_IMEM) ? imemAddr : dmemAddr));
                lastGnt = expWin;
            end
            for (int i = 0; i < 4; i++) begin
                respond($sformatf("tie_rsp%0d", i), SCR1_MEM_RESP_RDY_OK, 64'hA5);
            end
        end
`else
        // Fixed priority: DMEM takes every tie
        begin
            int iAcks;
            int dAcks;
            iAcks = 0;
            dAcks = 0;
            for (int i = 0; i < 3; i++) begin
                ordQ.push_back(SCR1_ARB_DMEM);
                applyStimulus(1'b1, 1'b1, 1'b1, SCR1_MEM_RESP_NOTRDY, 64'h0);
                iAcks += int'(imemReqAck);
                dAcks += int'(dmemReqAck);
            end
            checkOutput("prio_dmem_acks", 64'(dAcks), 64'd3);
            checkOutput("prio_imem_acks", 64'(iAcks), 64'd0);
            for (int i = 0; i < 3; i++) begin
                respond($sformatf("prio_rsp%0d", i), SCR1_MEM_RESP_RDY_OK, 64'hA5);
            end
        end
`endif

        // Make IMEM the last grant, so only HOLD keeps DMEM out below
        issueOne("pre", SCR1_ARB_IMEM);
        respond("pre_rsp", SCR1_MEM_RESP_RDY_OK, 64'h11);

        applyStimulus(1'b1, 1'b0, 1'b0, SCR1_MEM_RESP_NOTRDY, 64'h0);
        checkOutput("hold0_mem_req", 64'(memReq), 64'h1);
        checkOutput("hold0_addr", 64'(memAddr), 64'h100);
        checkOutput("hold0_imem_ack", 64'(imemReqAck), 64'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, SCR1_MEM_RESP_NOTRDY, 64'h0);
        checkOutput("hold1_addr", 64'(memAddr), 64'h100);
        checkOutput("hold1_dmem_ack", 64'(dmemReqAck), 64'h0);
        ordQ.push_back(SCR1_ARB_IMEM);
        applyStimulus(1'b1, 1'b1, 1'b1, SCR1_MEM_RESP_NOTRDY, 64'h0);
        checkOutput("hold2_addr", 64'(memAddr), 64'h100);
        checkOutput("hold2_imem_ack", 64'(imemReqAck), 64'h1);
        checkOutput("hold2_dmem_ack", 64'(dmemReqAck), 64'h0);
        issueOne("hold3", SCR1_ARB_DMEM);
        respond("hold_rsp0", SCR1_MEM_RESP_RDY_OK, 64'h21);
        respond("hold_rsp1", SCR1_MEM_RESP_RDY_OK, 64'h22);

        // Full FIFO stalls; a same-cycle pop does not bypass the stall
        for (int i = 0; i < 4; i++) begin
            issueOne($sformatf("fill%0d", i), SCR1_ARB_IMEM);
        end
        applyStimulus(1'b1, 1'b0, 1'b1, SCR1_MEM_RESP_NOTRDY, 64'h0);
        checkOutput("full_mem_req", 64'(memReq), 64'h0);
        checkOutput("full_imem_ack", 64'(imemReqAck), 64'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, SCR1_MEM_RESP_RDY_OK, 64'h31);
        checkOutput("full_nobypass", 64'(memReq), 64'h0);
        checkRouting("full_pop", SCR1_MEM_RESP_RDY_OK, 64'h31);
        ordQ.push_back(SCR1_ARB_IMEM);
        applyStimulus(1'b1, 1'b0, 1'b1, SCR1_MEM_RESP_NOTRDY, 64'h0);
        checkOutput("full_release", 64'(memReq), 64'h1);
        checkOutput("full_release_ack", 64'(imemReqAck), 64'h1);
        for (int i = 0; i < 4; i++) begin
            respond($sformatf("drain%0d", i), SCR1_MEM_RESP_RDY_OK, 64'h40 + 64'(i));
        end

        // Error response routes and pops like OK
        dmemCmd = SCR1_MEM_CMD_WR;
        issueOne("err_wr", SCR1_ARB_DMEM);
        checkOutput("err_cmd", 64'(memCmd), 64'(SCR1_MEM_CMD_WR));
        respond("err", SCR1_MEM_RESP_RDY_ER, 64'h0);
        checkOutput("err_idle_busy", 64'(arbIdle), 64'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, SCR1_MEM_RESP_NOTRDY, 64'h0);
        checkOutput("err_idle_done", 64'(arbIdle), 64'h1);
        dmemCmd = SCR1_MEM_CMD_RD;

        // Spurious response with nothing outstanding
        checkOutput("spur_err_pre", 64'(arbErr), 64'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, SCR1_MEM_RESP_RDY_OK, 64'h33);
        checkOutput("spur_imem_resp", 64'(imemResp), 64'(SCR1_MEM_RESP_NOTRDY));
        checkOutput("spur_dmem_resp", 64'(dmemResp), 64'(SCR1_MEM_RESP_NOTRDY));
        checkOutput("spur_imem_rdata", imemRdata, 64'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, SCR1_MEM_RESP_NOTRDY, 64'h0);
        checkOutput("spur_err_set", 64'(arbErr), 64'h1);

        // Reset with two transactions outstanding
        issueOne("out0", SCR1_ARB_IMEM);
        issueOne("out1", SCR1_ARB_DMEM);
        checkOutput("out_idle", 64'(arbIdle), 64'h0);
        @(posedge clk);
        #1;
        imemReq   = 1'b1;
        memReqAck = 1'b1;
        memResp   = SCR1_MEM_RESP_RDY_OK;
        memRdata  = 64'h44;
        rst_n     = 1'b0;
        #1;
        checkOutput("mrst_err", 64'(arbErr), 64'h0);
        checkOutput("mrst_idle_hi", 64'(arbIdle), 64'h1);
        checkOutput("mrst_mem_req", 64'(memReq), 64'h0);
        checkOutput("mrst_imem_ack", 64'(imemReqAck), 64'h0);
        checkOutput("mrst_imem_resp", 64'(imemResp), 64'(SCR1_MEM_RESP_NOTRDY));
        memIdle = 1'b0;
        #1;
        checkOutput("mrst_idle_lo", 64'(arbIdle), 64'h0);
        memIdle   = 1'b1;
        imemReq   = 1'b0;
        memReqAck = 1'b0;
        memResp   = SCR1_MEM_RESP_NOTRDY;
        memRdata  = 64'h0;
        ordQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, SCR1_MEM_RESP_NOTRDY, 64'h0);
        checkOutput("post_idle", 64'(arbIdle), 64'h1);
        checkOutput("post_err", 64'(arbErr), 64'h0);
        issueOne("post", SCR1_ARB_DMEM);
        respond("post_rsp", SCR1_MEM_RESP_RDY_OK, 64'h55);
        checkOutput("post_err_clean", 64'(arbErr), 64'h0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
